// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 prefix bytes, parser state encoding and event word layout
package ps2_pkg;
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam int EVT_W = 10;
    typedef enum logic [1:0] {S_BASE, S_EXT, S_BRK, S_EXT_BRK} ps2_state_t;
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;
endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: synchronous FIFO, pointers one bit wider than the address to tell full from empty
module ps2_evt_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = wr_ptr == rd_ptr;
    assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign do_pop = pop && !empty;
    // a pop frees the slot, so push while full is fine when popping
    assign do_push = push && (!full || do_pop);
    assign head = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes E0/F0 prefixed PS/2 bytes into key events, queues them,
// counts makes and tracks the held key
module ps2_key_tracker #(
    parameter int CNT_W         = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_FILTER = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_pop_n,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic [CNT_W-1:0] key_cnt,
    output logic             key_held,
    output logic [7:0]       held_code,
    output logic             held_ext,
    output logic             evt_ovf,
    input  logic             clr
);
    import ps2_pkg::*;
    ps2_state_t st, st_n;
    ps2_evt_t head;
    logic take, done, ext, brk, match, rpt, push, make_ok, pop, full, empty;
    assign take = byte_valid && byte_pop_n;
    assign ext = st == S_EXT || st == S_EXT_BRK;
    assign brk = st == S_BRK || st == S_EXT_BRK;
    always_comb begin
        st_n = st;
        done = 1'b0;
        if (take) begin
            if (byte_data == PS2_EXT)
                st_n = (st == S_BASE) ? S_EXT : st;
            else if (byte_data == PS2_BRK)
                st_n = (st == S_BASE) ? S_BRK : (st == S_EXT) ? S_EXT_BRK : st;
            else begin
                st_n = S_BASE;
                done = 1'b1;
            end
        end
    end
    assign match = key_held && {ext, byte_data} == {held_ext, held_code};
    // typematic repeat of the held key: no push, no count
    assign rpt = (REPEAT_FILTER != 0) && !brk && match;
    assign push = done && !rpt;
    assign make_ok = push && !brk;
    assign pop = evt_valid && evt_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= S_BASE;
            byte_pop_n <= 1'b1;
            key_cnt <= '0;
            evt_ovf <= 1'b0;
            key_held <= 1'b0;
            held_code <= '0;
            held_ext <= 1'b0;
        end else begin
            st <= st_n;
            byte_pop_n <= !take;
            key_cnt <= clr ? '0 : make_ok ? key_cnt + 1'b1 : key_cnt;
            evt_ovf <= clr ? 1'b0 : (push && full && !pop) ? 1'b1 : evt_ovf;
            if (make_ok) begin
                key_held <= 1'b1;
                held_code <= byte_data;
                held_ext <= ext;
            end else if (push && brk && match) key_held <= 1'b0;
        end
    end
    ps2_evt_fifo #(.W(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .din({ext, brk, byte_data}),
        .full(full),
        .empty(empty),
        .head(head)
    );
    assign evt_valid = !empty;
    assign evt_code = head.code;
    assign evt_ext = head.ext;
    assign evt_break = head.brk;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: three configurations (default, no repeat filter, 4-bit counter)
// driven in lockstep and compared against an event-level model every cycle
module tb_ps2_key_tracker;
    logic clk = 1'b0, rst = 1'b1, byte_valid = 1'b0, evt_ready = 1'b0, clr = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic pn [3], ev [3], ex [3], bk [3], kh [3], hx [3], ov [3];
    logic [7:0] ec [3], hc [3];
    logic [7:0] kc0, kc1;
    logic [3:0] kc2;
    int n_chk = 0, n_fail = 0;
    // model state
    int q [3][$];
    bit held_m [3], ovf_m [3];
    logic [8:0] hkey_m [3];
    int cnt_m [3];
    bit pe, pb, pn_m;
    int rf [3] = '{1, 0, 1};
    int cw [3] = '{8, 8, 4};

    always #5 clk = ~clk;

    ps2_key_tracker dut0 (.clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_pop_n(pn[0]), .evt_valid(ev[0]), .evt_ready(evt_ready), .evt_code(ec[0]),
        .evt_ext(ex[0]), .evt_break(bk[0]), .key_cnt(kc0), .key_held(kh[0]), .held_code(hc[0]),
        .held_ext(hx[0]), .evt_ovf(ov[0]), .clr(clr));
    ps2_key_tracker #(.REPEAT_FILTER(0)) dut1 (.clk(clk), .rst(rst), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_pop_n(pn[1]), .evt_valid(ev[1]), .evt_ready(evt_ready),
        .evt_code(ec[1]), .evt_ext(ex[1]), .evt_break(bk[1]), .key_cnt(kc1), .key_held(kh[1]),
        .held_code(hc[1]), .held_ext(hx[1]), .evt_ovf(ov[1]), .clr(clr));
    ps2_key_tracker #(.CNT_W(4)) dut2 (.clk(clk), .rst(rst), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_pop_n(pn[2]), .evt_valid(ev[2]), .evt_ready(evt_ready),
        .evt_code(ec[2]), .evt_ext(ex[2]), .evt_break(bk[2]), .key_cnt(kc2), .key_held(kh[2]),
        .held_code(hc[2]), .held_ext(hx[2]), .evt_ovf(ov[2]), .clr(clr));

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_cnt(input int k);
        return k == 0 ? {24'h0, kc0} : k == 1 ? {24'h0, kc1} : {28'h0, kc2};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            held_m[k] = 0;
            ovf_m[k] = 0;
            hkey_m[k] = '0;
            cnt_m[k] = 0;
        end
        pe = 0;
        pb = 0;
        pn_m = 1;
    endtask

    task automatic model_edge(input logic bv, input logic [7:0] bd, input logic rdy, input logic c);
        bit consume, has, e_ext, e_brk, popk, pushk, fullk;
        logic [8:0] key;
        consume = bv && pn_m;
        has = 0;
        e_ext = 0;
        e_brk = 0;
        pn_m = !consume;
        if (consume) begin
            if (bd == 8'hE0) begin
                if (!pe && !pb) pe = 1;
            end else if (bd == 8'hF0) pb = 1;
            else begin
                has = 1;
                e_ext = pe;
                e_brk = pb;
                pe = 0;
                pb = 0;
            end
        end
        key = {e_ext, bd};
        for (int k = 0; k < 3; k++) begin
            popk = rdy && q[k].size() > 0;
            fullk = q[k].size() == 4;
            pushk = 0;
            if (has && !e_brk) begin
                if (!(rf[k] != 0 && held_m[k] && hkey_m[k] == key)) begin
                    pushk = 1;
                    cnt_m[k]++;
                    held_m[k] = 1;
                    hkey_m[k] = key;
                end
            end else if (has) begin
                pushk = 1;
                if (held_m[k] && hkey_m[k] == key) held_m[k] = 0;
            end
            if (popk) void'(q[k].pop_front());
            if (pushk && fullk && !popk) ovf_m[k] = 1;
            else if (pushk) q[k].push_back((int'(e_ext) << 9) | (int'(e_brk) << 8) | int'(bd));
            if (c) begin
                cnt_m[k] = 0;
                ovf_m[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("byte_pop_n[%0d]", k), 32'(pn[k]), 32'(pn_m));
            chk($sformatf("evt_valid[%0d]", k), 32'(ev[k]), 32'(q[k].size() > 0));
            if (q[k].size() > 0)
                chk($sformatf("evt_head[%0d]", k), {22'h0, ex[k], bk[k], ec[k]}, 32'(q[k][0]));
            chk($sformatf("key_cnt[%0d]", k), get_cnt(k), 32'(cnt_m[k] % (1 << cw[k])));
            chk($sformatf("key_held[%0d]", k), 32'(kh[k]), 32'(held_m[k]));
            chk($sformatf("held_key[%0d]", k), {23'h0, hx[k], hc[k]}, {23'h0, hkey_m[k]});
            chk($sformatf("evt_ovf[%0d]", k), 32'(ov[k]), 32'(ovf_m[k]));
        end
    endtask

    task automatic check_reset();
        check_all();
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_head[%0d]", k), {22'h0, ex[k], bk[k], ec[k]}, 32'h0);
    endtask

    task automatic step(input logic bv, input logic [7:0] bd, input logic rdy, input logic c);
        byte_valid = bv;
        byte_data = bd;
        evt_ready = rdy;
        clr = c;
        @(posedge clk);
        model_edge(bv, bd, rdy, c);
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input logic [7:0] b, input logic rdy);
        step(1'b1, b, rdy, 1'b0);
        step(1'b0, 8'h00, rdy, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        byte_valid = 1'b0;
        evt_ready = 1'b0;
        clr = 1'b0;
        #1;
        model_reset();
        check_reset();
        @(negedge clk);
        check_reset();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0] b;
        int cnt;
        bit held;
        bit valid;
    } vec_t;

    initial begin
        vec_t tbl [8];
        int n [3];
        tbl[0] = '{8'h1C, 1, 1, 1};
        tbl[1] = '{8'hF0, 1, 1, 1};
        tbl[2] = '{8'h1C, 1, 0, 1};
        tbl[3] = '{8'hE0, 1, 0, 1};
        tbl[4] = '{8'h75, 2, 1, 1};
        tbl[5] = '{8'hE0, 2, 1, 1};
        tbl[6] = '{8'hF0, 2, 1, 1};
        tbl[7] = '{8'h75, 2, 0, 1};
        model_reset();
        @(negedge clk);
        check_reset();
        rst = 1'b0;

        // basic make/break and extended sequences
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].b, 1'b0);
            chk($sformatf("tbl_cnt[%0d]", i), {24'h0, kc0}, 32'(tbl[i].cnt));
            chk($sformatf("tbl_held[%0d]", i), 32'(kh[0]), 32'(tbl[i].held));
            chk($sformatf("tbl_valid[%0d]", i), 32'(ev[0]), 32'(tbl[i].valid));
        end
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // typematic repeat filtering
        do_reset();
        send(8'h1C, 1'b0);
        send(8'h1C, 1'b0);
        send(8'h1C, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        chk("rpt_cnt_filtered", {24'h0, kc0}, 32'd1);
        chk("rpt_cnt_unfiltered", {24'h0, kc1}, 32'd3);
        n = '{0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 3; k++) if (ev[k]) n[k]++;
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("rpt_events_filtered", 32'(n[0]), 32'd2);
        chk("rpt_events_unfiltered", 32'(n[1]), 32'd4);

        // overflow, in-order drain, clear
        do_reset();
        for (int i = 0; i < 5; i++) send(8'h11 + 8'(i), 1'b0);
        chk("ovf_set", 32'(ov[0]), 32'd1);
        chk("ovf_cnt", {24'h0, kc0}, 32'd5);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("ovf_sticky", 32'(ov[0]), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_cnt", {24'h0, kc0}, 32'd0);
        chk("clr_ovf", 32'(ov[0]), 32'd0);

        // counter wrap on the 4-bit instance
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send(8'h20 + 8'(i), 1'b1);
            send(8'hF0, 1'b1);
            send(8'h20 + 8'(i), 1'b1);
        end
        chk("wrap_cnt4", {28'h0, kc2}, 32'd1);
        chk("wrap_cnt8", {24'h0, kc0}, 32'd17);

        // reset in the middle of an E0 F0 prefix
        do_reset();
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        do_reset();
        send(8'h1C, 1'b0);
        chk("midrst_valid", 32'(ev[0]), 32'd1);
        chk("midrst_evt", {22'h0, ex[0], bk[0], ec[0]}, 32'h01C);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            b = r < 2 ? 8'hE0 : r < 4 ? 8'hF0 : r < 7 ? 8'h1C : r < 9 ? 8'h75 : 8'($urandom_range(0, 255));
            step($urandom_range(0, 2) != 0, b, $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised PS/2 scan-code parser between the `ps2_keyboard` byte receiver and the display/ASCII logic. It pops raw bytes from the receiver and decodes `E0` extended and `F0` break prefixes into complete key events. Events are queued in a configurable-depth FIFO with a valid/ready consumer handshake. The block also keeps a wrap-around press counter, held-key tracking with optional typematic-repeat filtering, and a sticky event-overflow flag.

## Interface

Parameters:

- `CNT_W`, default 8: width of the press counter.
- `FIFO_DEPTH`, default 4: event FIFO entries; must be a power of two and at least 2.
- `REPEAT_FILTER`, default 1: when 1, a repeated make of the currently held key is suppressed.

Ports:

- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `byte_valid` in 1: receiver has a byte (receiver `ready`).
- `byte_data` in 8: receiver head byte.
- `byte_pop_n` out 1: active-low pop strobe to the receiver (`nextdata_n`).
- `evt_valid` out 1: event FIFO non-empty.
- `evt_ready` in 1: consumer accepts the head event.
- `evt_code` out 8: head event scan code.
- `evt_ext` out 1: head event was `E0`-prefixed.
- `evt_break` out 1: head event is a release.
- `key_cnt` out CNT_W: accepted make events, modulo 2^CNT_W.
- `key_held` out 1: a key is currently held.
- `held_code` out 8: code of the held key.
- `held_ext` out 1: ext flag of the held key.
- `evt_ovf` out 1: sticky flag, set when an event was dropped because the FIFO was full.
- `clr` in 1: synchronous clear of `key_cnt` and `evt_ovf`.

## Operation

- Byte consume:
  - When `byte_valid`=1 and `byte_pop_n`=1, the byte is processed and `byte_pop_n` is registered low for exactly one cycle.
  - While `byte_pop_n`=0, `byte_valid` is ignored. This absorbs the receiver's one-cycle pointer update.
  - Maximum rate is one byte per 2 cycles. Bytes are never stalled by FIFO state.
- Parser states: S_BASE, S_EXT, S_BRK, S_EXT_BRK.
  - `E0`: S_BASE goes to S_EXT. `E0` in any other state is ignored and the state holds.
  - `F0`: S_BASE goes to S_BRK, and S_EXT goes to S_EXT_BRK. `F0` in S_BRK or S_EXT_BRK is ignored.
  - Any other byte completes an event, with `ext` = (state is S_EXT or S_EXT_BRK) and `break` = (state is S_BRK or S_EXT_BRK). The state then returns to S_BASE.
- Make event:
  - If REPEAT_FILTER=1, `key_held`=1 and {ext,code} equals {`held_ext`,`held_code`}, the make is a repeat. It is suppressed: no push, no count.
  - Otherwise the event is pushed, `key_cnt` increments, and the held registers load {ext,code} with `key_held`=1.
- Break event:
  - The event is always pushed.
  - If {ext,code} matches the held key, `key_held` clears. `held_code`/`held_ext` keep their last value.
  - A break of a non-held key leaves the held state unchanged.
- FIFO full on push:
  - The event is dropped and `evt_ovf` is set.
  - `key_cnt` and the held state still update.
  - A push and a pop in the same cycle while full is not an overflow: both are performed.
- `key_cnt` wraps from all-ones to 0.
- `clr` has priority over an increment in the same cycle. It affects only `key_cnt` and `evt_ovf`.

## Timing

- Reset values:
  - `byte_pop_n`=1, `evt_valid`=0, `evt_code`=0, `evt_ext`=0, `evt_break`=0.
  - `key_cnt`=0, `key_held`=0, `held_code`=0, `held_ext`=0, `evt_ovf`=0.
  - Parser in S_BASE, FIFO empty.
- Reset mid-sequence (for example after `E0 F0`) discards the partial prefix and all queued events.
- Latency: the completing byte sampled at edge N gives `evt_valid`=1 after edge N, provided the FIFO was empty. `key_cnt`, `key_held` and the held registers update at the same edge.
- Event outputs come straight from the FIFO head register. There is no combinational path from `byte_data` to the `evt_*` outputs.
- A pop occurs on an edge where `evt_valid`&&`evt_ready`. `evt_ready` while empty has no effect.

## Structure

- Package `ps2_pkg` holds:
  - byte constants `PS2_EXT`=8'hE0 and `PS2_BRK`=8'hF0;
  - the parser state encoding;
  - the event word layout {ext, break, code[7:0]}, 10 bits.
- Sub-module `ps2_evt_fifo`:
  - synchronous FIFO parametrised by width and depth;
  - pointers one bit wider than the address, for the full/empty distinction;
  - ports for push, pop, full, empty and head.

## Test plan

- Bytes `1C, F0, 1C` -> events {0,0,1C} then {0,1,1C}; `key_cnt`=1; `key_held` goes 1 then 0; `byte_pop_n` pulses 3 times, each low exactly 1 cycle.
- Bytes `E0 75, E0 F0 75` -> events {1,0,75} then {1,1,75}; `key_held`=0 afterwards.
- REPEAT_FILTER=1, bytes `1C 1C 1C F0 1C` -> 2 events, `key_cnt`=1. Same bytes with REPEAT_FILTER=0 -> 4 events, `key_cnt`=3.
- FIFO_DEPTH=4, `evt_ready`=0, 5 distinct makes -> 4 events queued, `evt_ovf`=1, `key_cnt`=5. Drain -> codes in arrival order. Pulse `clr` -> `key_cnt`=0, `evt_ovf`=0.
- CNT_W=4, 17 distinct make/break pairs -> `key_cnt`=1 (wrapped).
- Assert `rst` after `E0 F0`, then send `1C` -> event {0,0,1C}; every output was at its reset value during `rst`.
